// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the shared memory and the arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it (core + memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        dbg_state;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output dbg_state
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  dbg_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and load/store (D),
// one transaction in flight, with a watchdog that turns a missing mem_ack into an error response.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    // Handshake: a request is taken only in the cycle its ready is high (IDLE, rst low); the
    // response is a single-cycle rvalid strobe with rdata/err, issued in RESP to the owner.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [7:0]        cnt;
    logic              grant_i;
    logic              grant_d;
    logic              busy;
    logic              resp_i;
    logic              resp_d;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    // On a tie the requester that did not win last time goes next.
                    if (bus.i_req && (!bus.d_req || last_grant)) grant_i = 1'b1;
                    else if (bus.d_req)                          grant_d = 1'b1;
                end
                if (grant_i || grant_d) state_next = BUSY;
            end
            BUSY: begin
                if (bus.mem_ack || cnt == CNT_LAST) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= bus.i_addr;
                        wdata_q    <= '0;
                        cnt        <= 8'd0;
                    end else if (grant_d) begin
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        we_q       <= bus.d_we;
                        addr_q     <= bus.d_addr;
                        wdata_q    <= bus.d_wdata;
                        cnt        <= 8'd0;
                    end
                end
                BUSY: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (bus.mem_ack) begin
                        rdata_q <= we_q ? '0 : bus.mem_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == BUSY);
    assign resp_i = (state == RESP) && !owner;
    assign resp_d = (state == RESP) && owner;

    assign bus.i_ready   = grant_i;
    assign bus.d_ready   = grant_d;
    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy & we_q;
    assign bus.mem_addr  = busy ? addr_q : '0;
    assign bus.mem_wdata = busy ? wdata_q : '0;

    assign bus.i_rvalid  = resp_i;
    assign bus.i_rdata   = resp_i ? rdata_q : '0;
    assign bus.i_err     = resp_i & err_q;
    assign bus.d_rvalid  = resp_d;
    assign bus.d_rdata   = resp_d ? rdata_q : '0;
    assign bus.d_err     = resp_d & err_q;

    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked each cycle against
// a look-ahead transaction model that plans each grant's window and response from the ack table.
module tb_mem_port_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 4096;
    localparam int RAND_END = 3000;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    // memory behaviour planned per cycle, so the model can look ahead from a grant
    logic          ack_tab  [NCYC];
    logic [DW-1:0] rdat_tab [NCYC];

    // requester inputs for the next cycle
    logic          s_rst;
    logic          s_i_req;
    logic [AW-1:0] s_i_addr;
    logic          s_d_req;
    logic          s_d_we;
    logic [AW-1:0] s_d_addr;
    logic [DW-1:0] s_d_wdata;

    // reference model
    int            free_at;
    int            win_lo;
    int            win_hi;
    int            resp_cyc;
    bit            last;
    bit            m_owner;
    bit            m_we;
    bit            m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            g_i;
    bit            g_d;
    logic [DW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_check();
        int            c;
        int            ack_at;
        bit            in_win;
        bit            is_resp;
        logic [DW-1:0] exp_data;
        c   = cyc;
        g_i = 1'b0;
        g_d = 1'b0;
        if (!s_rst && c >= free_at) begin
            if (s_i_req && s_d_req) begin
                g_i = last;
                g_d = !last;
            end else begin
                g_i = s_i_req;
                g_d = s_d_req;
            end
            if (g_i || g_d) begin
                m_owner = g_d;
                last    = g_d;
                m_we    = g_d ? s_d_we : 1'b0;
                m_addr  = g_d ? s_d_addr : s_i_addr;
                m_wdata = g_d ? s_d_wdata : '0;
                ack_at  = -1;
                for (int k = 1; k <= TIMEOUT; k++)
                    if (ack_at < 0 && ack_tab[c + k]) ack_at = c + k;
                win_lo   = c + 1;
                win_hi   = (ack_at < 0) ? c + TIMEOUT : ack_at;
                resp_cyc = win_hi + 1;
                m_err    = (ack_at < 0);
                exp_q.push_back((ack_at < 0 || m_we) ? '0 : rdat_tab[ack_at]);
                free_at  = resp_cyc + 1;
            end
        end

        check_eq("i_ready", bus.i_ready, g_i);
        check_eq("d_ready", bus.d_ready, g_d);
        check_eq("ready_excl", bus.i_ready & bus.d_ready, 0);

        in_win = (c >= win_lo) && (c <= win_hi);
        check_eq("mem_req", bus.mem_req, in_win);
        if (in_win) begin
            check_eq("mem_we", bus.mem_we, m_we);
            check_eq("mem_addr", bus.mem_addr, m_addr);
            check_eq("mem_wdata", bus.mem_wdata, m_wdata);
        end

        is_resp  = (c == resp_cyc);
        exp_data = '0;
        if (is_resp && exp_q.size() > 0) exp_data = exp_q.pop_front();
        check_eq("i_rvalid", bus.i_rvalid, is_resp && !m_owner);
        check_eq("i_rdata", bus.i_rdata, (is_resp && !m_owner) ? exp_data : '0);
        check_eq("i_err", bus.i_err, is_resp && !m_owner && m_err);
        check_eq("d_rvalid", bus.d_rvalid, is_resp && m_owner);
        check_eq("d_rdata", bus.d_rdata, (is_resp && m_owner) ? exp_data : '0);
        check_eq("d_err", bus.d_err, is_resp && m_owner && m_err);

        // reset aborts whatever is still pending after this cycle
        if (s_rst) begin
            last    = 1'b1;
            free_at = c + 1;
            if (win_hi > c) win_hi = c;
            if (resp_cyc > c) begin
                resp_cyc = -1;
                exp_q.delete();
            end
        end
    endtask

    // driver: apply inputs just after the edge, check mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc           = cyc + 1;
        rst           = s_rst;
        bus.i_req     = s_i_req;
        bus.i_addr    = s_i_addr;
        bus.d_req     = s_d_req;
        bus.d_we      = s_d_we;
        bus.d_addr    = s_d_addr;
        bus.d_wdata   = s_d_wdata;
        bus.mem_ack   = ack_tab[cyc];
        bus.mem_rdata = rdat_tab[cyc];
        @(negedge clk);
        model_check();
    endtask

    task automatic run_to_idle();
        for (int n = 0; n < 40 && cyc < free_at; n++) step();
    endtask

    task automatic fire(input bit is_d, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int ack_delay, input logic [DW-1:0] rdata);
        int c0;
        c0 = cyc + 1;
        if (ack_delay > 0) begin
            ack_tab[c0 + ack_delay]  = 1'b1;
            rdat_tab[c0 + ack_delay] = rdata;
        end
        if (is_d) begin
            s_d_req = 1'b1; s_d_we = we; s_d_addr = addr; s_d_wdata = wdata;
        end else begin
            s_i_req = 1'b1; s_i_addr = addr;
        end
        step();
        s_i_req = 1'b0;
        s_d_req = 1'b0;
        run_to_idle();
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int c0;
        int mode;
        for (int i = 0; i < NCYC; i++) begin
            ack_tab[i]  = 1'b0;
            rdat_tab[i] = '0;
        end
        s_rst = 1'b1; s_i_req = 1'b0; s_i_addr = '0;
        s_d_req = 1'b0; s_d_we = 1'b0; s_d_addr = '0; s_d_wdata = '0;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        free_at = 0; win_lo = 1; win_hi = 0; resp_cyc = -1; last = 1'b1;
        m_owner = 1'b0; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
        cyc = -1;
        @(posedge clk);

        // reset: requests held during rst must not be granted
        s_i_req = 1'b1; s_d_req = 1'b1;
        repeat (3) step();
        s_i_req = 1'b0; s_d_req = 1'b0; s_rst = 1'b0;
        repeat (2) step();

        // single fetch, immediate ack
        fire(1'b0, 1'b0, 32'h4, '0, 1, 32'hFFC4_A303);
        // store acked on its third BUSY cycle; read data must be discarded
        fire(1'b1, 1'b1, 32'h2008, 32'h0000_000A, 3, 32'hDEAD_BEEF);

        // timeout on a load, followed by stray acks that must be ignored
        c0 = cyc + 1;
        for (int k = TIMEOUT + 1; k <= TIMEOUT + 3; k++) begin
            ack_tab[c0 + k]  = 1'b1;
            rdat_tab[c0 + k] = 32'hBAD0_0000 + k;
        end
        fire(1'b1, 1'b0, 32'h3000, '0, 0, '0);
        repeat (4) step();

        // ack exactly on the timeout cycle
        fire(1'b0, 1'b0, 32'h40, '0, TIMEOUT, 32'h1234_5678);

        // contention: both held, acks every cycle
        for (int k = 1; k <= 14; k++) begin
            ack_tab[cyc + k]  = 1'b1;
            rdat_tab[cyc + k] = $urandom;
        end
        s_i_req = 1'b1; s_i_addr = 32'h100;
        s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 32'h8000; s_d_wdata = '0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (g_i) s_i_addr = s_i_addr + 32'd4;
            if (g_d) s_d_addr = s_d_addr + 32'd4;
        end
        s_i_req = 1'b0; s_d_req = 1'b0;
        run_to_idle();
        step();

        // reset on the second BUSY cycle, then a tie must go to I
        c0 = cyc + 1;
        ack_tab[c0 + 10] = 1'b1; rdat_tab[c0 + 10] = 32'h5555_AAAA;
        s_d_req = 1'b1; s_d_we = 1'b0; s_d_addr = 32'h500;
        step();
        s_d_req = 1'b0;
        step();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0; s_i_req = 1'b1; s_i_addr = 32'h600; s_d_req = 1'b1; s_d_addr = 32'h700;
        step();
        s_i_req = 1'b0;
        step();
        s_d_req = 1'b0;
        run_to_idle();
        step();

        // random traffic; some ack-free stretches force timeouts
        mode = 0;
        for (int c = cyc + 1; c < NCYC; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 3);
            ack_tab[c]  = (mode == 0) ? 1'b0 :
                          (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            rdat_tab[c] = $urandom;
        end
        while (cyc < RAND_END) begin
            if (g_i || !s_i_req) begin
                s_i_req  = ($urandom_range(0, 2) != 0);
                s_i_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) begin
                s_i_req = 1'b0;
            end
            if (g_d || !s_d_req) begin
                s_d_req   = ($urandom_range(0, 2) != 0);
                s_d_we    = 1'($urandom_range(0, 1));
                s_d_addr  = $urandom & 32'hFFFF_FFFC;
                s_d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                s_d_req = 1'b0;
            end
            s_rst = ($urandom_range(0, 199) == 0);
            step();
        end
        s_rst = 1'b0; s_i_req = 1'b0; s_d_req = 1'b0;
        run_to_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
